// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared types for the data-memory arbiter:
//   - arb_state_e : arbiter FSM encoding (IDLE = 1'b0, SERVE = 1'b1)
//   - REQ_CPU / REQ_LDR : requester ids (load/store stage, loader/debug port)
//   - id_to_onehot : requester id -> one-hot grant / rvalid vector
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } arb_state_e;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_LDR = 1'b1;

   function automatic logic [1:0] id_to_onehot(input logic id);
      return (id == REQ_LDR) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way winner select. A lone request always wins; when both
// requesters are active the one named by i_prio wins.
// Ports:
//   i_req    [1:0] per-requester request
//   i_prio         requester id that wins a tie
//   o_valid        at least one request present
//   o_winner       winning requester id (REQ_CPU when no request)
// -----------------------------------------------------------------------------
module rr_arb2
   import dmem_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_prio,
   output logic       o_valid,
   output logic       o_winner
);

   always_comb begin
      o_valid  = |i_req;
      o_winner = REQ_CPU;
      case (i_req)
         2'b01:   o_winner = REQ_CPU;
         2'b10:   o_winner = REQ_LDR;
         2'b11:   o_winner = i_prio;
         default: o_winner = REQ_CPU;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Round-robin arbiter sharing a single-cycle data_memory between requester 0
// (CPU load/store stage) and requester 1 (loader/debug port). The winning
// command is latched in IDLE, presented to memory for exactly one SERVE cycle,
// and read data comes back registered with a one-hot rvalid_o pulse.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   req_i, we_i                   per-requester request / write enable
//   addr0_i, addr1_i              requester addresses
//   wdata0_i, wdata1_i            requester write data
//   gnt_o, rvalid_o               one-cycle one-hot grant / read-valid pulses
//   rdata_o                       registered read data (shared)
//   mem_address, write_data,
//   MemRead, MemWrite             to data_memory (zero outside SERVE)
//   read_data                     from data_memory (combinational read)
//   grant_cnt0_o, grant_cnt1_o    saturating grant counters, present only when
//                                 DMEM_ARB_STATS_EN is defined (width CNT_W)
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req_i,
   input  logic [1:0]        we_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic [DATA_W-1:0] wdata1_i,
   output logic [1:0]        gnt_o,
   output logic [1:0]        rvalid_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] write_data,
   output logic              MemRead,
   output logic              MemWrite,
   input  logic [DATA_W-1:0] read_data
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]  grant_cnt0_o,
   output logic [CNT_W-1:0]  grant_cnt1_o
`endif
);

   arb_state_e        r_state;
   logic              r_prio;
   logic              r_id;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [1:0]        r_gnt;
   logic [1:0]        r_rvalid;
   logic [DATA_W-1:0] r_rdata;

   logic              w_valid;
   logic              w_winner;
   logic              w_serve;

   rr_arb2 u_rr_arb2 (
      .i_req    (req_i),
      .i_prio   (r_prio),
      .o_valid  (w_valid),
      .o_winner (w_winner)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_prio   <= REQ_CPU;
         r_id     <= REQ_CPU;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_gnt    <= '0;
         r_rvalid <= '0;
         r_rdata  <= '0;
      end else begin
         r_gnt    <= '0;
         r_rvalid <= '0;
         case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_id    <= w_winner;
                  r_we    <= we_i[w_winner];
                  r_addr  <= (w_winner == REQ_LDR) ? addr1_i : addr0_i;
                  r_wdata <= (w_winner == REQ_LDR) ? wdata1_i : wdata0_i;
                  r_gnt   <= id_to_onehot(w_winner);
                  // Loser of this round owns the next tie.
                  r_prio  <= ~w_winner;
                  r_state <= SERVE;
               end
            end
            SERVE: begin
               if (!r_we) begin
                  r_rdata  <= read_data;
                  r_rvalid <= id_to_onehot(r_id);
               end
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Memory strobes decode straight from state so an asynchronous reset
   // mid-SERVE removes MemWrite before the memory's write edge.
   assign w_serve     = (r_state == SERVE);
   assign mem_address = w_serve ? r_addr : '0;
   assign write_data  = w_serve ? r_wdata : '0;
   assign MemWrite    = w_serve & r_we;
   assign MemRead     = w_serve & ~r_we;

   assign gnt_o    = r_gnt;
   assign rvalid_o = r_rvalid;
   assign rdata_o  = r_rdata;

`ifdef DMEM_ARB_STATS_EN
   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [CNT_W-1:0] r_cnt0;
   logic [CNT_W-1:0] r_cnt1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (r_gnt[0] && (r_cnt0 != CntMax)) r_cnt0 <= r_cnt0 + 1'b1;
         if (r_gnt[1] && (r_cnt1 != CntMax)) r_cnt1 <= r_cnt1 + 1'b1;
      end
   end

   assign grant_cnt0_o = r_cnt0;
   assign grant_cnt1_o = r_cnt1;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Scoreboard bench for dmem_arbiter with a 16-word behavioural data_memory.
// Stimulus pushes expected grants, memory accesses and read returns into
// queues; a negedge monitor pops and compares whenever the DUT shows them.
// Compile with DMEM_ARB_STATS_EN defined to also exercise the grant counters.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } acc_t;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] data;
   } rv_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_i, we_i;
   logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
   logic [1:0]  gnt_o, rvalid_o;
   logic [31:0] rdata_o, mem_address, write_data, read_data;
   logic        MemRead, MemWrite;
`ifdef DMEM_ARB_STATS_EN
   logic [1:0]  cnt0, cnt1;
`endif

   logic [31:0] mem [0:15];
   logic        pl_en;
   logic [3:0]  pl_addr;
   logic [31:0] pl_data;

   logic [1:0]  gnt_q [$];
   acc_t        acc_q [$];
   rv_t         rv_q  [$];

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0]  mon_gnt;
   acc_t        mon_acc;
   rv_t         mon_rv;

   always #5 clk = ~clk;

   dmem_arbiter #(.CNT_W(2)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .req_i        (req_i),
      .we_i         (we_i),
      .addr0_i      (addr0_i),
      .addr1_i      (addr1_i),
      .wdata0_i     (wdata0_i),
      .wdata1_i     (wdata1_i),
      .gnt_o        (gnt_o),
      .rvalid_o     (rvalid_o),
      .rdata_o      (rdata_o),
      .mem_address  (mem_address),
      .write_data   (write_data),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .read_data    (read_data)
`ifdef DMEM_ARB_STATS_EN
      ,
      .grant_cnt0_o (cnt0),
      .grant_cnt1_o (cnt1)
`endif
   );

   // Behavioural single-cycle data_memory: combinational read, posedge write.
   assign read_data = mem[mem_address[3:0]];
   always @(posedge clk) begin
      if (pl_en)         mem[pl_addr] <= pl_data;
      else if (MemWrite) mem[mem_address[3:0]] <= write_data;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the queued expectations.
   always @(negedge clk) begin
      if (!reset) begin
         if (gnt_o != 2'b00) begin
            if (gnt_q.size() == 0) check("gnt_unexpected", 64'(gnt_o), 64'd0);
            else begin
               mon_gnt = gnt_q.pop_front();
               check("gnt", 64'(gnt_o), 64'(mon_gnt));
            end
         end
         if (MemRead || MemWrite) begin
            check("mem_rw_exclusive", 64'(MemRead & MemWrite), 64'd0);
            if (acc_q.size() == 0) check("mem_access_unexpected", 64'(mem_address), 64'hDEAD);
            else begin
               mon_acc = acc_q.pop_front();
               check("mem_write_strobe", 64'(MemWrite), 64'(mon_acc.we));
               check("mem_address", 64'(mem_address), 64'(mon_acc.addr));
               if (mon_acc.we) check("mem_write_data", 64'(write_data), 64'(mon_acc.wdata));
            end
         end
         if (rvalid_o != 2'b00) begin
            if (rv_q.size() == 0) check("rvalid_unexpected", 64'(rvalid_o), 64'd0);
            else begin
               mon_rv = rv_q.pop_front();
               check("rvalid_id", 64'(rvalid_o), 64'(mon_rv.id));
               check("rdata", 64'(rdata_o), 64'(mon_rv.data));
            end
         end
      end
   end

   task automatic push_txn(input logic id, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata);
      logic [1:0] oh;
      oh = id ? 2'b10 : 2'b01;
      gnt_q.push_back(oh);
      acc_q.push_back('{we: we, addr: addr, wdata: wdata});
      if (!we) rv_q.push_back('{id: oh, data: exp_rdata});
   endtask

   // Single-requester transaction: hold the command until the grant is seen.
   task automatic req_one(input logic id, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata);
      bit got;
      push_txn(id, we, addr, wdata, exp_rdata);
      @(posedge clk); #1;
      req_i     = 2'b00;
      req_i[id] = 1'b1;
      we_i[id]  = we;
      if (id) begin addr1_i = addr; wdata1_i = wdata; end
      else    begin addr0_i = addr; wdata0_i = wdata; end
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (gnt_o[id]) got = 1'b1;
      end
      if (!got) check("gnt_timeout", 64'd0, 64'd1);
      req_i = 2'b00;
      we_i  = 2'b00;
   endtask

   task automatic drain();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0] rr_exp [8];
      rr_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

      reset = 1'b1; req_i = '0; we_i = '0;
      addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;

      #1;
      check("reset_pulses", 64'({gnt_o, rvalid_o, MemRead, MemWrite}), 64'd0);
      check("reset_rdata", 64'(rdata_o), 64'd0);
      check("reset_mem_address", 64'(mem_address), 64'd0);
      check("reset_write_data", 64'(write_data), 64'd0);

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         pl_en   = 1'b1;
         pl_addr = 4'(i);
         pl_data = 32'h1000_0000 + 32'(i);
         if (i == 1) pl_data = 32'hA5A5_A5A5;
         if (i == 3) pl_data = 32'h0;
         if (i == 4) pl_data = 32'hE000_0000;
      end
      @(negedge clk) pl_en = 1'b0;
      @(negedge clk) reset = 1'b0;

      // Read by requester 0, write by requester 1, read-back.
      req_one(1'b0, 1'b0, 32'd4, 32'd0, 32'hE000_0000);
      drain();
      req_one(1'b1, 1'b1, 32'd3, 32'h1234_5678, 32'd0);
      @(posedge clk); #1;
      check("wr_no_rvalid", 64'(rvalid_o), 64'd0);
      check("wr_rdata_hold", 64'(rdata_o), 64'hE000_0000);
      req_one(1'b0, 1'b0, 32'd3, 32'd0, 32'h1234_5678);
      drain();

      // Both requesting continuously after reset: grants alternate from 0.
      pulse_reset();
      for (int i = 0; i < 2; i++) begin
         push_txn(1'b0, 1'b0, 32'd4, 32'd0, 32'hE000_0000);
         push_txn(1'b1, 1'b0, 32'd3, 32'd0, 32'h1234_5678);
      end
      @(posedge clk); #1;
      req_i = 2'b11; we_i = 2'b00; addr0_i = 32'd4; addr1_i = 32'd3;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check($sformatf("rr_gnt_%0d", i), 64'(gnt_o), 64'(rr_exp[i]));
      end
      req_i = 2'b00;
      drain();

      // Reset in the SERVE cycle of a write: write aborted, outputs cleared.
      @(posedge clk); #1;
      req_i = 2'b10; we_i = 2'b10; addr1_i = 32'd1; wdata1_i = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      check("abort_gnt", 64'(gnt_o), 64'h2);
      check("abort_memwrite_pre", 64'(MemWrite), 64'd1);
      #1;
      reset = 1'b1; req_i = 2'b00; we_i = 2'b00;
      #1;
      check("abort_pulses", 64'({gnt_o, rvalid_o, MemRead, MemWrite}), 64'd0);
      check("abort_mem_bus", 64'({mem_address, write_data}), 64'd0);
      check("abort_rdata", 64'(rdata_o), 64'd0);
      @(posedge clk);
      @(negedge clk) reset = 1'b0;
      check("abort_mem1_unchanged", 64'(mem[1]), 64'hA5A5_A5A5);

      // Next grant after reset goes to requester 0 even with both requesting.
      push_txn(1'b0, 1'b0, 32'd4, 32'd0, 32'hE000_0000);
      @(posedge clk); #1;
      req_i = 2'b11; we_i = 2'b00; addr0_i = 32'd4; addr1_i = 32'd1;
      @(posedge clk); #1;
      check("post_reset_gnt", 64'(gnt_o), 64'h1);
      req_i = 2'b00;
      drain();

      // Idle: nothing moves.
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("idle_pulses", 64'({gnt_o, rvalid_o, MemRead, MemWrite}), 64'd0);
         check("idle_mem_bus", 64'({mem_address, write_data}), 64'd0);
      end

`ifdef DMEM_ARB_STATS_EN
      pulse_reset();
      check("stats_reset", 64'({cnt0, cnt1}), 64'd0);
      for (int i = 0; i < 5; i++) req_one(1'b0, 1'b0, 32'd4, 32'd0, 32'hE000_0000);
      drain();
      check("stats_cnt0_sat", 64'(cnt0), 64'd3);
      check("stats_cnt1", 64'(cnt1), 64'd0);
`endif

      drain();
      check("sb_gnt_left", 64'(gnt_q.size()), 64'd0);
      check("sb_acc_left", 64'(acc_q.size()), 64'd0);
      check("sb_rv_left", 64'(rv_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter that shares the single-cycle data_memory between requester 0 (CPU load/store stage) and requester 1 (loader/debug port).
- Registers the winning command, drives mem_address/write_data/MemRead/MemWrite for exactly one cycle, and returns read data with a valid pulse.
- Sits between the requesters and data_memory.

Parameters:
ADDR_W, 32, address width of requesters and memory
DATA_W, 32, data width
CNT_W, 16, grant-counter width (used only with DMEM_ARB_STATS_EN)

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-high reset
req_i  input  2  per-requester request; bit n = requester n
we_i  input  2  per-requester write enable (1 = write, 0 = read)
addr0_i / addr1_i  input  ADDR_W  requester addresses
wdata0_i / wdata1_i  input  DATA_W  requester write data
gnt_o  output  2  one-cycle grant pulse, one-hot or zero
rvalid_o  output  2  one-cycle read-data-valid pulse, one-hot or zero
rdata_o  output  DATA_W  registered read data, shared by both requesters
mem_address  output  ADDR_W  to data_memory
write_data  output  DATA_W  to data_memory
MemRead  output  1  to data_memory
MemWrite  output  1  to data_memory
read_data  input  DATA_W  from data_memory (combinational read)
grant_cnt0_o / grant_cnt1_o  output  CNT_W  only when DMEM_ARB_STATS_EN is defined

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; prio=0; latched command cleared; gnt_o=0, rvalid_o=0, rdata_o=0, mem_address=0, write_data=0, MemRead=0, MemWrite=0.
- FSM states: IDLE, SERVE.
- IDLE, cycle N, req_i!=0:
  - Winner: single request wins. If both request, requester prio wins.
  - At posedge end of N: latch winner id, we, addr, wdata. gnt_o[winner]=1 (registered, visible in N+1). prio <= ~winner. State -> SERVE.
- IDLE with req_i==0: no change.
- SERVE (cycle N+1):
  - mem_address/write_data driven from latch. MemWrite=latched we. MemRead=~latched we.
  - data_memory writes at posedge end of N+1.
  - For reads, rdata_o <= read_data at that edge, and rvalid_o[winner]=1 during N+2.
  - For writes, rdata_o holds its value and rvalid_o stays 0.
  - State -> IDLE unconditionally.
- Memory outputs are 0 whenever state != SERVE. MemRead and MemWrite are never both 1.
- Throughput: one access per 2 cycles. A new request may be sampled in N+2, the same cycle as rvalid_o.
- Requester rule:
  - Hold req/we/addr/wdata stable until gnt_o is seen; the command is taken from cycle N.
  - Deassert req in the gnt cycle unless issuing a new command.
  - req is ignored during SERVE.
- Both requesting continuously: grants alternate 0,1,0,1… starting with 0 after reset.
- Reset during SERVE: MemWrite drops immediately, the pending write is not performed, and no rvalid_o is issued.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Ports grant_cnt0_o/grant_cnt1_o exist.
  - Each counter increments on its gnt_o pulse and saturates at 2^CNT_W-1.
  - Reset clears both to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, SERVE=1'b1) and requester ids (REQ_CPU=0, REQ_LDR=1).
- One natural sub-module: rr_arb2. It is a combinational winner select from req_i and prio, and is reusable.
- FSM, command latch and counters stay in dmem_arbiter.

Test Plan:
- Read by requester 0, with mem[4]=32'hE0000000 preloaded: req_i=01, we=0, addr0=4 in cycle N.
  - Expect gnt_o=01 in N+1, MemRead=1 and mem_address=4 in N+1.
  - Expect rvalid_o=01 and rdata_o=32'hE0000000 in N+2.
- Write by requester 1: addr1=3, wdata1=32'h12345678.
  - Expect gnt_o=10 and MemWrite=1 for exactly one cycle, with no rvalid_o.
  - A subsequent read of addr 3 returns 32'h12345678.
- Both requesting continuously for 8 cycles after reset: gnt_o sequence is 01,00,10,00,01,00,10,00 and MemRead/MemWrite are never both 1.
- Reset asserted mid-SERVE of a write to addr 1 (data 32'hFFFFFFFF): all outputs go to 0 immediately, mem[1] is unchanged, and the next grant goes to requester 0.
- req_i=00 for 10 cycles: all memory outputs stay 0 and gnt_o/rvalid_o stay 00.
- With DMEM_ARB_STATS_EN, CNT_W=2, after 5 grants to requester 0: grant_cnt0_o=3 (saturated) and grant_cnt1_o=0.
